// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between the icache refill
// path and the dcache refill/writeback path. Each transaction is one address
// handshake, then its data beats, then the port is released. Requesters are
// never interleaved. Read beats pass straight through with no added latency.
module mem_bus_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  // icache refill side
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic                i_rlast,
  // dcache refill / writeback side
  input  logic                d_req,
  input  logic                d_op,
  input  logic                d_single,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_wnext,
  output logic                d_rvalid,
  output logic                d_rlast,
  output logic                d_bdone,
  output logic [DATA_W-1:0]   rdata,
  // downstream memory port
  output logic                m_req,
  output logic                m_op,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [7:0]          m_len,
  input  logic                m_ready,
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_wready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_bvalid,
  output logic                proto_err
);

  // Beats-1 for a full cache line, as carried on m_len.
  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_ADDR  = 3'd1,
    I_DATA  = 3'd2,
    D_ADDR  = 3'd3,
    D_RDATA = 3'd4,
    D_WDATA = 3'd5,
    D_WRESP = 3'd6
  } state_e;

  state_e     state_q,     state_d;
  logic       last_i_q,    last_i_d;     // 1: icache held the most recent grant
  logic [7:0] beat_cnt_q,  beat_cnt_d;
  logic [7:0] len_q,       len_d;        // beats-1 of the transaction in flight
  logic       op_q,        op_d;         // dcache op latched at arbitration
  logic       proto_err_q, proto_err_d;
  logic       bdone_q,     bdone_d;

  assign proto_err = proto_err_q;
  assign d_bdone   = bdone_q;

  // State and bookkeeping registers; reset lands in IDLE with icache as last grantee.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b1;
      beat_cnt_q  <= 8'd0;
      len_q       <= 8'd0;
      op_q        <= 1'b0;
      proto_err_q <= 1'b0;
      bdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      op_q        <= op_d;
      proto_err_q <= proto_err_d;
      bdone_q     <= bdone_d;
    end
  end

  // Next-state, arbitration, beat counting and per-state output steering.
  always_comb begin
    state_d     = state_q;
    last_i_d    = last_i_q;
    beat_cnt_d  = beat_cnt_q;
    len_d       = len_q;
    op_d        = op_q;
    proto_err_d = proto_err_q;
    bdone_d     = 1'b0;

    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    d_gnt    = 1'b0;
    d_wnext  = 1'b0;
    d_rvalid = 1'b0;
    d_rlast  = 1'b0;
    rdata    = {DATA_W{1'b0}};
    m_req    = 1'b0;
    m_op     = 1'b0;
    m_addr   = {ADDR_W{1'b0}};
    m_len    = 8'd0;
    m_wvalid = 1'b0;
    m_wdata  = {DATA_W{1'b0}};
    m_wstrb  = {(DATA_W/8){1'b0}};
    m_wlast  = 1'b0;

    case (state_q)
      IDLE: begin
        // dcache wins when alone, or on a tie when icache had the last grant.
        if (d_req && (!i_req || last_i_q)) begin
          state_d  = D_ADDR;
          last_i_d = 1'b0;
          len_d    = d_single ? 8'd0 : LINE_LEN;
          op_d     = d_op;
        end else if (i_req) begin
          state_d  = I_ADDR;
          last_i_d = 1'b1;
          len_d    = LINE_LEN;
          op_d     = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end

      I_ADDR: begin
        m_req  = 1'b1;
        m_op   = 1'b0;
        m_addr = i_addr;
        m_len  = len_q;
        if (m_ready) begin
          i_gnt      = 1'b1;
          beat_cnt_d = 8'd0;
          state_d    = I_DATA;
        end else begin
          state_d    = I_ADDR;
        end
      end

      D_ADDR: begin
        m_req  = 1'b1;
        m_op   = d_op;
        m_addr = d_addr;
        m_len  = len_q;
        if (m_ready) begin
          d_gnt      = 1'b1;
          beat_cnt_d = 8'd0;
          state_d    = op_q ? D_WDATA : D_RDATA;
        end else begin
          state_d    = D_ADDR;
        end
      end

      I_DATA, D_RDATA: begin
        rdata = m_rdata;
        if (state_q == I_DATA) begin
          i_rvalid = m_rvalid;
          i_rlast  = m_rvalid & m_rlast;
        end else begin
          d_rvalid = m_rvalid;
          d_rlast  = m_rvalid & m_rlast;
        end
        if (m_rvalid) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (m_rlast) begin
            state_d = IDLE;
            if (beat_cnt_q != len_q) begin
              proto_err_d = 1'b1;
            end else begin
              proto_err_d = proto_err_q;
            end
          end else if (beat_cnt_q == len_q) begin
            // Final beat arrived without m_rlast.
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = proto_err_q;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end

      D_WDATA: begin
        m_wvalid = 1'b1;
        m_wdata  = d_wdata;
        m_wstrb  = d_wstrb;
        m_wlast  = (beat_cnt_q == len_q);
        if (m_wready) begin
          d_wnext    = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == len_q) begin
            state_d = D_WRESP;
          end else begin
            state_d = D_WDATA;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end

      D_WRESP: begin
        if (m_bvalid) begin
          bdone_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = D_WRESP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: drives both cache requesters and a randomized memory
// model, predicting grant order, burst lengths, beat routing and error flags
// from transaction-level rules.
module tb_mem_bus_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int LB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, i_gnt, i_rvalid, i_rlast;
  logic [AW-1:0] i_addr;
  logic          d_req, d_op, d_single, d_gnt, d_wnext, d_rvalid, d_rlast, d_bdone;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, rdata;
  logic [7:0]    d_wstrb;
  logic          m_req, m_op, m_ready, m_wvalid, m_wlast, m_wready;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [7:0]    m_wstrb;
  logic          m_rvalid, m_rlast, m_bvalid, proto_err;

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .d_req(d_req), .d_op(d_op), .d_single(d_single), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_wnext(d_wnext),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_bdone(d_bdone), .rdata(rdata),
    .m_req(m_req), .m_op(m_op), .m_addr(m_addr), .m_len(m_len), .m_ready(m_ready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_bvalid(m_bvalid), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending requests, who was granted last, sticky error.
  bit            exp_last_i;
  bit            exp_perr;
  bit            i_pend, d_pend, d_op_r, d_single_r;
  logic [AW-1:0] i_addr_r, d_addr_r;
  logic [DW-1:0] wbeat [LB];
  logic [7:0]    wstrb_b [LB];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive_reqs();
    i_req    = i_pend;
    i_addr   = i_addr_r;
    d_req    = d_pend;
    d_op     = d_op_r;
    d_single = d_single_r;
    d_addr   = d_addr_r;
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_op = 1'b0; d_single = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; m_ready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {i_gnt, i_rvalid, i_rlast, d_gnt, d_wnext, d_rvalid, d_rlast,
                             d_bdone, m_req, m_op, m_wvalid, m_wlast, proto_err}, 64'd0);
    check_eq({tag, "_maddr"}, m_addr, 64'd0);
    check_eq({tag, "_mlen"},  {56'd0, m_len}, 64'd0);
    check_eq({tag, "_wdata"}, m_wdata, 64'd0);
    check_eq({tag, "_rdata"}, rdata, 64'd0);
  endtask

  // Apply reset for one cycle; reference model returns to its reset view.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    i_pend = 1'b0; d_pend = 1'b0; d_op_r = 1'b0; d_single_r = 1'b0;
    exp_last_i = 1'b1;
    exp_perr   = 1'b0;
    settle();
    check_all_zero("reset");
    tick();
    rst = 1'b1;
  endtask

  // Serve one transaction starting in an IDLE cycle. early>=0 ends a read
  // burst with m_rlast on that beat index; rdly<0 picks a random ready delay.
  task automatic serve(input int early, input int rdly);
    bit            win_i, op;
    logic [7:0]    len;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            k, nb, idx, guard;
    bit            rdy;
    drive_reqs();
    win_i = (i_pend && d_pend) ? !exp_last_i : i_pend;
    exp_last_i = win_i;
    len  = win_i ? 8'(LB - 1) : (d_single_r ? 8'd0 : 8'(LB - 1));
    op   = win_i ? 1'b0 : d_op_r;
    addr = win_i ? i_addr_r : d_addr_r;
    settle();
    check_eq("idle_mreq", m_req, 1'b0);
    check_eq("idle_gnt", {i_gnt, d_gnt}, 2'b00);
    tick();
    // address phase
    k = (rdly < 0) ? int'($urandom_range(0, 2)) : rdly;
    for (int c = 0; c < k; c++) begin
      m_ready = 1'b0;
      settle();
      check_eq("addr_mreq", m_req, 1'b1);
      check_eq("addr_maddr", m_addr, addr);
      check_eq("addr_mlen", m_len, len);
      check_eq("addr_mop", m_op, op);
      check_eq("addr_nognt", {i_gnt, d_gnt}, 2'b00);
      tick();
    end
    m_ready = 1'b1;
    settle();
    check_eq("hs_maddr", m_addr, addr);
    check_eq("hs_mlen", m_len, len);
    check_eq("hs_gnt", {i_gnt, d_gnt}, {win_i, !win_i});
    tick();
    m_ready = 1'b0;
    if (win_i) i_pend = 1'b0; else d_pend = 1'b0;
    drive_reqs();
    if (!op) begin
      nb = (early >= 0) ? early + 1 : int'(len) + 1;
      for (int b = 0; b < nb; b++) begin
        k = $urandom_range(0, 2);
        for (int g = 0; g < k; g++) begin
          m_rvalid = 1'b0;
          settle();
          check_eq("gap_rvalid", {i_rvalid, d_rvalid}, 2'b00);
          check_eq("gap_mreq", m_req, 1'b0);
          tick();
        end
        data = {$urandom, $urandom};
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rlast  = (b == nb - 1);
        settle();
        check_eq("rd_route", {i_rvalid, d_rvalid}, {win_i, !win_i});
        check_eq("rd_data", rdata, data);
        check_eq("rd_rlast", {i_rlast, d_rlast},
                 (b == nb - 1) ? {win_i, !win_i} : 2'b00);
        tick();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      if (nb - 1 != int'(len)) exp_perr = 1'b1;
    end else begin
      for (int b = 0; b <= int'(len); b++) begin
        wbeat[b]   = {$urandom, $urandom};
        wstrb_b[b] = 8'($urandom);
      end
      idx = 0;
      guard = 0;
      while (idx <= int'(len) && guard < 100) begin
        d_wdata  = wbeat[idx];
        d_wstrb  = wstrb_b[idx];
        rdy      = 1'($urandom_range(0, 1));
        m_wready = rdy;
        settle();
        check_eq("wr_valid", m_wvalid, 1'b1);
        check_eq("wr_data", m_wdata, wbeat[idx]);
        check_eq("wr_strb", m_wstrb, wstrb_b[idx]);
        check_eq("wr_last", m_wlast, (idx == int'(len)));
        check_eq("wr_wnext", d_wnext, rdy);
        tick();
        if (rdy) idx++;
        guard++;
      end
      m_wready = 1'b0;
      check_eq("wr_budget", idx, int'(len) + 1);
      k = $urandom_range(0, 2);
      for (int g = 0; g < k; g++) begin
        settle();
        check_eq("resp_wvalid", m_wvalid, 1'b0);
        check_eq("resp_bdone", d_bdone, 1'b0);
        tick();
      end
      m_bvalid = 1'b1;
      settle();
      check_eq("resp_bdone_early", d_bdone, 1'b0);
      tick();
      m_bvalid = 1'b0;
      check_eq("bdone_pulse", d_bdone, 1'b1);
    end
    check_eq("proto_err", proto_err, exp_perr);
  endtask

  // Top-level sequence: directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // icache-only line fill
    i_pend = 1'b1; i_addr_r = 64'h0000_0000_8000_0040;
    serve(-1, 2);

    // simultaneous requests: dcache first, then icache
    i_pend = 1'b1; i_addr_r = 64'h0000_0000_8000_0080;
    d_pend = 1'b1; d_op_r = 1'b0; d_single_r = 1'b0; d_addr_r = 64'h0000_0000_8000_2000;
    serve(-1, -1);
    serve(-1, -1);

    // dcache writeback burst
    d_pend = 1'b1; d_op_r = 1'b1; d_single_r = 1'b0; d_addr_r = 64'h0000_0000_8000_1000;
    serve(-1, -1);

    // single-beat uncached read, then a burst read
    d_pend = 1'b1; d_op_r = 1'b0; d_single_r = 1'b1; d_addr_r = 64'h0000_0000_1000_0000;
    serve(-1, 0);
    d_pend = 1'b1; d_op_r = 1'b0; d_single_r = 1'b0; d_addr_r = 64'h0000_0000_8000_3000;
    serve(-1, 1);

    // premature m_rlast on beat 3 of 4; error stays set across later traffic
    i_pend = 1'b1; i_addr_r = 64'h0000_0000_8000_4000;
    serve(2, 0);
    d_pend = 1'b1; d_op_r = 1'b1; d_single_r = 1'b1; d_addr_r = 64'h0000_0000_1000_0008;
    serve(-1, 0);
    do_reset();

    // randomized mixed traffic
    for (int it = 0; it < 60; it++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend = 1'b1;
        i_addr_r = {$urandom, $urandom} & ~64'h3f;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1;
        d_op_r = 1'($urandom_range(0, 1));
        d_single_r = ($urandom_range(0, 3) == 0);
        d_addr_r = {$urandom, $urandom} & ~64'h7;
      end
      if (!i_pend && !d_pend) begin
        drive_reqs();
        settle();
        check_eq("quiet_mreq", m_req, 1'b0);
        tick();
      end else begin
        serve(-1, -1);
      end
    end

    // reset during beat 2 of a write burst
    clear_inputs();
    d_pend = 1'b1; d_op_r = 1'b1; d_single_r = 1'b0; d_addr_r = 64'h0000_0000_8000_5000;
    drive_reqs();
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; d_req = 1'b0;
    d_wdata = 64'h1111_2222_3333_4444; d_wstrb = 8'hff; m_wready = 1'b1;
    settle();
    check_eq("mid_wvalid", m_wvalid, 1'b1);
    tick();
    d_wdata = 64'h5555_6666_7777_8888; m_wready = 1'b0;
    #1;
    check_eq("mid_beat2", m_wvalid, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_inputs();
    tick();
    rst = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0; exp_last_i = 1'b1; exp_perr = 1'b0;
    i_pend = 1'b1; i_addr_r = 64'h0000_0000_8000_6000;
    serve(-1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sequences whole transactions: one address handshake, then N data beats, then release of the port. It never interleaves requesters.
- Sits between the icache/dcache miss handlers and the SoC memory interface. It keeps the dcache request path started by the execute stage independent of ifetch misses.

Parameters:
- DATA_W, 64, data beat width in bits.
- ADDR_W, 64, address width in bits.
- LINE_BEATS, 4, beats per cache-line burst (1..256).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- i_req  in  1  icache refill request (read only, LINE_BEATS beats)
- i_addr  in  ADDR_W  icache line address
- i_gnt  out  1  icache request accepted downstream (1-cycle pulse)
- i_rvalid  out  1  icache read beat valid
- i_rlast  out  1  last icache beat
- d_req  in  1  dcache request
- d_op  in  1  0=read, 1=write
- d_single  in  1  1=single-beat uncached (MMIO) access, 0=LINE_BEATS burst
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  DATA_W  current write beat
- d_wstrb  in  DATA_W/8  current write strobe
- d_gnt  out  1  dcache request accepted downstream (1-cycle pulse)
- d_wnext  out  1  current write beat consumed; present next beat
- d_rvalid  out  1  dcache read beat valid
- d_rlast  out  1  last dcache read beat
- d_bdone  out  1  write transaction complete (1-cycle pulse)
- rdata  out  DATA_W  read data, shared by both sides (qualified by i_rvalid/d_rvalid)
- m_req  out  1  downstream request valid
- m_op  out  1  downstream op
- m_addr  out  ADDR_W  downstream address
- m_len  out  8  beats-1
- m_ready  in  1  downstream request accepted
- m_wvalid, m_wdata, m_wstrb, m_wlast  out  1/DATA_W/DATA_W/8/1  write beat channel
- m_wready  in  1  write beat accepted
- m_rvalid, m_rdata, m_rlast  in  1/DATA_W/1  read beat channel
- m_bvalid  in  1  write response
- proto_err  out  1  sticky: m_rlast disagrees with the beat counter

Behaviour:
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_RDATA, D_WDATA, D_WRESP.
- Reset (rst=0, async):
  - state=IDLE, last_grant=I (dcache wins the first tie), beat_cnt=0, proto_err=0.
  - All outputs are 0.
- IDLE arbitration:
  - Only i_req: go to I_ADDR.
  - Only d_req: go to D_ADDR.
  - Both: grant the side not equal to last_grant (round-robin).
  - last_grant updates on entry to an ADDR state.
  - Requests are sampled in IDLE only. Deassertion after grant is ignored until the transaction ends.
- ADDR states:
  - m_req=1 with m_op/m_addr/m_len driven from the granted side, combinationally from its inputs.
  - Requesters hold their inputs stable until gnt.
  - m_len = LINE_BEATS-1, or 0 when d_single=1 (d_single is latched at grant).
  - On m_req&m_ready: pulse i_gnt or d_gnt, clear beat_cnt, then go to I_DATA, D_RDATA or D_WDATA.
- Read data states:
  - rdata=m_rdata. i_rvalid or d_rvalid = m_rvalid, routed to the owner only.
  - beat_cnt increments on each m_rvalid and wraps at 8 bits.
  - rlast mirrors m_rlast.
  - When m_rvalid&m_rlast: go to IDLE.
  - Also set proto_err if beat_cnt != latched len at m_rlast, or if beat_cnt == len and m_rlast=0.
  - Reads have 0-cycle added latency (combinational pass-through).
- D_WDATA:
  - m_wvalid=1, m_wdata=d_wdata, m_wstrb=d_wstrb, m_wlast=(beat_cnt==len).
  - On m_wvalid&m_wready: d_wnext=1 and beat_cnt++. If it was the last beat, go to D_WRESP.
- D_WRESP: on m_bvalid, d_bdone=1, go to IDLE.
- A new arbitration can occur in the cycle after return to IDLE. Minimum turnaround between transactions is 1 idle cycle.
- m_req is never asserted outside the ADDR states.
- m_rvalid outside read data states is ignored; it does not set proto_err.
- There is no abort: a pipeline flush in the core does not cancel an in-flight transaction. The requester discards the data itself.
- Reset asserted mid-burst: return immediately to IDLE with outputs 0. The downstream side is assumed to be reset by the same rst.

Test Plan:
- i_req only, addr 0x8000_0040, m_ready after 2 cycles, 4 read beats with gaps -> m_len=3, i_gnt pulses once, i_rvalid x4 with i_rlast on beat 4, d_* outputs stay 0.
- i_req and d_req (read) raised in the same cycle after reset -> dcache granted first. icache is granted in the cycle after dcache m_rlast+1 idle cycle, with no beats misrouted.
- dcache writeback 0x8000_1000, 4 beats, m_wready toggling 1,0,1,1,0,1 -> d_wnext x4, m_wlast on beat 4 only. d_bdone pulses 1 cycle after m_bvalid, state returns to IDLE.
- d_single=1 read of 0x1000_0000 -> m_len=0, one d_rvalid with d_rlast. A following burst request uses m_len=3.
- Burst returns m_rlast on beat 3 of 4 -> proto_err=1 and stays 1 until rst=0; the FSM returns to IDLE.
- rst driven low during beat 2 of a write -> all outputs 0 asynchronously. After release a fresh i_req is granted normally.
